// File: rtl/piso_register.sv
// piso_register: loads a parallel word and shifts it out one bit per shift_en strobe
module piso_register #(
  parameter int DataSize = 8,
  parameter int MsbFirst = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DataSize-1:0] d,
  input  logic                shift_en,
  output logic                q,
  output logic                busy,
  output logic                done
);
  localparam int CW = (DataSize > 1) ? $clog2(DataSize) : 1;
  localparam logic [CW-1:0] LAST = CW'(DataSize - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e state_q = IDLE;
  logic [DataSize-1:0] shadow_q = '0;
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic q_q = 1'b0;
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  logic first_bit, next_bit;
  // bit selection for the word being loaded and for the next counter position
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    first_bit = (MsbFirst != 0) ? d[DataSize-1] : d[0];
    next_bit = shadow_q[(MsbFirst != 0) ? LAST - cnt_d : cnt_d];
  end
  // control FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shadow_q <= '0;
      cnt_q <= '0;
      q_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            shadow_q <= d;
            cnt_q <= '0;
            q_q <= first_bit;
            busy_q <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt_q == LAST) begin
              q_q <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_d;
              q_q <= next_bit;
            end
          end
        end
        default: begin
          done_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign q = q_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_piso_register.sv
// tb_piso_register: directed checks of MSB-first, LSB-first and single-bit serialisers
module tb_piso_register;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic [7:0] d = '0;
  logic shift_en = 1'b0;
  logic q_m, busy_m, done_m;
  logic q_l, busy_l, done_l;
  logic q_o, busy_o, done_o;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  piso_register #(.DataSize(8), .MsbFirst(1)) u_msb (
    .clk(clk), .reset(reset), .load(load), .d(d), .shift_en(shift_en),
    .q(q_m), .busy(busy_m), .done(done_m)
  );
  piso_register #(.DataSize(8), .MsbFirst(0)) u_lsb (
    .clk(clk), .reset(reset), .load(load), .d(d), .shift_en(shift_en),
    .q(q_l), .busy(busy_l), .done(done_l)
  );
  piso_register #(.DataSize(1), .MsbFirst(1)) u_one (
    .clk(clk), .reset(reset), .load(load), .d(d[0]), .shift_en(shift_en),
    .q(q_o), .busy(busy_o), .done(done_o)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    load = 1'b0;
    shift_en = 1'b1;
    repeat (20) tick();
    shift_en = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    reset = 1'b1;
    load = 1'b1;
    d = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({q_m, busy_m, done_m} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d q/busy/done=%b expected 000", i, {q_m, busy_m, done_m});
      end
      checks++;
      if ({q_o, busy_o, done_o} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold_one cyc%0d q/busy/done=%b expected 000", i, {q_o, busy_o, done_o});
      end
    end
    reset = 1'b0;
    load = 1'b0;
    tick();
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_capture q/busy/done=%b expected 000", {q_m, busy_m, done_m});
    end
  endtask
  task automatic test_msb_first;
    logic [7:0] e;
    e = 8'hA5;
    d = e;
    load = 1'b1;
    tick();
    load = 1'b0;
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q_m, busy_m, done_m} !== {e[7-i], 2'b10}) begin
        errors++;
        $display("FAIL msb_bit%0d q/busy/done=%b expected %b", i, {q_m, busy_m, done_m}, {e[7-i], 2'b10});
      end
      tick();
    end
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b001) begin
      errors++;
      $display("FAIL msb_done q/busy/done=%b expected 001", {q_m, busy_m, done_m});
    end
    tick();
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b000) begin
      errors++;
      $display("FAIL msb_idle q/busy/done=%b expected 000", {q_m, busy_m, done_m});
    end
    shift_en = 1'b0;
  endtask
  task automatic test_lsb_stall;
    int dones;
    d = 8'h01;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({q_l, busy_l, done_l} !== {(i == 0), 2'b10}) begin
          errors++;
          $display("FAIL lsb_bit%0d_cyc%0d q/busy/done=%b expected %b", i, k, {q_l, busy_l, done_l}, {(i == 0), 2'b10});
        end
        shift_en = (k == 2);
        tick();
      end
    end
    shift_en = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      dones += int'(done_l);
      if (i == 0) begin
        checks++;
        if ({q_l, busy_l, done_l} !== 3'b001) begin
          errors++;
          $display("FAIL lsb_done q/busy/done=%b expected 001", {q_l, busy_l, done_l});
        end
      end
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL lsb_done_count got %0d expected 1", dones);
    end
  endtask
  task automatic test_reload;
    logic [7:0] a, b;
    a = 8'hF0;
    b = 8'h0F;
    d = a;
    load = 1'b1;
    tick();
    d = b;
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q_m, busy_m} !== {a[7-i], 1'b1}) begin
        errors++;
        $display("FAIL reload_bit%0d q/busy=%b expected %b", i, {q_m, busy_m}, {a[7-i], 1'b1});
      end
      tick();
    end
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b001) begin
      errors++;
      $display("FAIL reload_done q/busy/done=%b expected 001", {q_m, busy_m, done_m});
    end
    tick();
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b000) begin
      errors++;
      $display("FAIL reload_idle q/busy/done=%b expected 000", {q_m, busy_m, done_m});
    end
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q_m, busy_m} !== {b[7-i], 1'b1}) begin
        errors++;
        $display("FAIL reload_second_bit%0d q/busy=%b expected %b", i, {q_m, busy_m}, {b[7-i], 1'b1});
      end
      tick();
    end
    checks++;
    if (done_m !== 1'b1) begin
      errors++;
      $display("FAIL reload_second_done done=%b expected 1", done_m);
    end
    shift_en = 1'b0;
  endtask
  task automatic test_midword_reset;
    logic [7:0] e;
    d = 8'hFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    shift_en = 1'b1;
    repeat (3) tick();
    checks++;
    if ({q_m, busy_m} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_pre q/busy=%b expected 11", {q_m, busy_m});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_abort q/busy/done=%b expected 000", {q_m, busy_m, done_m});
    end
    shift_en = 1'b0;
    tick();
    checks++;
    if ({busy_m, done_m} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_no_done busy/done=%b expected 00", {busy_m, done_m});
    end
    e = 8'h80;
    d = e;
    load = 1'b1;
    tick();
    load = 1'b0;
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({q_m, busy_m} !== {e[7-i], 1'b1}) begin
        errors++;
        $display("FAIL midreset_reload_bit%0d q/busy=%b expected %b", i, {q_m, busy_m}, {e[7-i], 1'b1});
      end
      tick();
    end
    checks++;
    if ({q_m, busy_m, done_m} !== 3'b001) begin
      errors++;
      $display("FAIL midreset_reload_done q/busy/done=%b expected 001", {q_m, busy_m, done_m});
    end
    shift_en = 1'b0;
  endtask
  task automatic test_single_bit;
    d = 8'h01;
    shift_en = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({q_o, busy_o, done_o} !== 3'b110) begin
        errors++;
        $display("FAIL single_hold cyc%0d q/busy/done=%b expected 110", i, {q_o, busy_o, done_o});
      end
      tick();
    end
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    checks++;
    if ({q_o, busy_o, done_o} !== 3'b001) begin
      errors++;
      $display("FAIL single_done q/busy/done=%b expected 001", {q_o, busy_o, done_o});
    end
    tick();
    checks++;
    if ({q_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle q/busy/done=%b expected 000", {q_o, busy_o, done_o});
    end
  endtask
  initial begin
    test_reset();
    test_msb_first();
    settle();
    test_lsb_stall();
    settle();
    test_reload();
    settle();
    test_midword_reset();
    settle();
    test_single_bit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
